// File: rtl/hazard_ctrl.sv
// hazard_ctrl: load-use bubbles, mult/div sequencing with timeout, and branch flush control.
// Optional STALL_PERF_EN adds a saturating stall_cycles counter output.
module hazard_ctrl #(
  parameter int MD_TIMEOUT = 40,
  parameter int CNT_W      = 6
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] fd_insn,
  input  logic [31:0] dx_insn,
  input  logic        branch_taken,
  input  logic        md_ready,
  output logic        pc_we,
  output logic        fd_we,
  output logic        fd_nop,
  output logic        dx_nop,
  output logic        xm_nop,
  output logic        md_start,
  output logic        md_result_sel,
  output logic        md_busy,
  output logic        md_timeout
`ifdef STALL_PERF_EN
  ,
  output logic [31:0] stall_cycles
`endif
);
  typedef enum logic [1:0] {RUN, ISSUE, WAIT, DONE} state_t;
  state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic timeout_q, timeout_d;
  logic [4:0] fd_op, fd_rd, fd_rs, fd_rt, dx_op, dx_rd, dx_alu;
  logic [3:0] fd_alu_hi;
  logic dx_is_md, rd_rs, rd_rt, rd_rd, load_use, run, hold, unused;
  assign fd_op     = fd_insn[31:27];
  assign fd_rd     = fd_insn[26:22];
  assign fd_rs     = fd_insn[21:17];
  assign fd_rt     = fd_insn[16:12];
  assign fd_alu_hi = fd_insn[6:3];
  assign dx_op     = dx_insn[31:27];
  assign dx_rd     = dx_insn[26:22];
  assign dx_alu    = dx_insn[6:2];
  assign unused    = ^{fd_insn[11:7], fd_insn[2:0], dx_insn[21:7], dx_insn[1:0]};
  assign dx_is_md = dx_op == 5'b00000 && (dx_alu == 5'b00110 || dx_alu == 5'b00111);
  assign rd_rs = fd_op inside {5'b00000, 5'b00101, 5'b01000, 5'b00111, 5'b00010, 5'b00110, 5'b01001};
  assign rd_rt = fd_op == 5'b00000 && fd_alu_hi != 4'b0010;
  // Store data in rd is forwarded W->M, so sw is deliberately absent here.
  assign rd_rd = fd_op inside {5'b00010, 5'b00110, 5'b00100, 5'b01001};
  assign load_use = dx_op == 5'b01000 && dx_rd != 5'd0 &&
                    ((rd_rs && fd_rs == dx_rd) || (rd_rt && fd_rt == dx_rd) || (rd_rd && fd_rd == dx_rd));
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= RUN;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    timeout_d = timeout_q;
    case (state_q)
      RUN:   state_d = dx_is_md ? ISSUE : RUN;
      ISSUE: begin
        state_d = WAIT;
        cnt_d   = '0;
      end
      WAIT: begin
        cnt_d = cnt_q + 1'b1;
        // A result arriving on the last allowed cycle is accepted without flagging.
        if (md_ready) state_d = DONE;
        else if (cnt_q == CNT_W'(MD_TIMEOUT - 1)) begin
          state_d   = DONE;
          timeout_d = 1'b1;
        end
      end
      default: state_d = RUN;
    endcase
  end
  always_comb begin
    run    = state_q == RUN;
    hold   = state_q == ISSUE || state_q == WAIT || (run && dx_is_md);
    pc_we  = !(hold || (run && !branch_taken && load_use));
    fd_we  = pc_we;
    xm_nop = hold;
    fd_nop = run && !dx_is_md && branch_taken;
    dx_nop = run && !dx_is_md && (branch_taken || load_use);
  end
  assign md_start      = state_q == ISSUE;
  assign md_result_sel = state_q == DONE;
  assign md_busy       = state_q != RUN;
  assign md_timeout    = timeout_q;
`ifdef STALL_PERF_EN
  logic [31:0] stall_q, stall_d;
  assign stall_d = (!pc_we && stall_q != 32'hFFFF_FFFF) ? stall_q + 32'd1 : stall_q;
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) stall_q <= '0;
    else stall_q <= stall_d;
  end
  assign stall_cycles = stall_q;
`endif
endmodule
